// File: rtl/cordic_hyp_ctrl.sv
// cordic_hyp_ctrl: hyperbolic CORDIC sequencer driving table index, shift and direction, and accumulating z.
// Define CORDIC_EXPANDED_RANGE_EN to prepend the expanded-range iterations -3..0 (19 steps instead of 15).
module cordic_hyp_ctrl #(
    parameter int W_Z = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic signed [W_Z-1:0] z_in,
    input  logic                  stall,
    input  logic                  y_neg,
    input  logic signed [W_Z-1:0] tbl_value,
    output logic signed [4:0]     tbl_index,
    output logic [4:0]            shift,
    output logic                  dir,
    output logic                  step_valid,
    output logic                  busy,
    output logic                  done,
    output logic signed [W_Z-1:0] z_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic mode_q, mode_d;
    logic signed [W_Z-1:0] z_q, z_d, z_out_q, z_out_d, z_step;
    logic signed [4:0] idx;
    logic run;
`ifdef CORDIC_EXPANDED_RANGE_EN
    localparam logic [4:0] LAST = 5'd18;
    // Slots 0..7 give -3..4, later slots lag by 4 so 4 repeats, and the final slot repeats 13.
    assign idx = (cnt_q <= 5'd7) ? $signed(cnt_q - 5'd3) : (cnt_q == LAST) ? 5'sd13 : $signed(cnt_q - 5'd4);
`else
    localparam logic [4:0] LAST = 5'd14;
    assign idx = (cnt_q <= 5'd3) ? $signed(cnt_q + 5'd1) : (cnt_q == LAST) ? 5'sd13 : $signed(cnt_q);
`endif
    assign run        = state_q == RUN;
    assign step_valid = run && !stall;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign tbl_index  = run ? idx : 5'sd0;
    assign shift      = !run ? 5'd0 : (idx <= 5'sd0) ? 5'd2 - $unsigned(idx) : $unsigned(idx);
    assign dir        = run && (mode_q ? y_neg : !z_q[W_Z-1]);
    assign z_step     = dir ? z_q - tbl_value : z_q + tbl_value;
    assign z_out      = z_out_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        z_d     = z_q;
        z_out_d = z_out_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                cnt_d   = '0;
                mode_d  = mode;
                z_d     = z_in;
            end
            RUN: if (step_valid) begin
                z_d   = z_step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    z_out_d = z_step;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            z_q     <= '0;
            z_out_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            z_q     <= z_d;
            z_out_q <= z_out_d;
        end
    end
endmodule

// File: tb/tb_cordic_hyp_ctrl.sv
// tb_cordic_hyp_ctrl: directed bench for the hyperbolic CORDIC sequencer; the bench supplies the arctanh table.
module tb_cordic_hyp_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic stall = 1'b0;
    logic y_neg = 1'b0;
    logic signed [31:0] z_in = '0;
    logic signed [31:0] tbl_value;
    logic signed [4:0] tbl_index;
    logic [4:0] shift;
    logic dir, step_valid, busy, done;
    logic signed [31:0] z_out;
    int n_checks = 0;
    int n_fail = 0;
    logic signed [31:0] zr;

`ifdef CORDIC_EXPANDED_RANGE_EN
    localparam int N = 19;
    localparam int EXP [N] = '{-3, -2, -1, 0, 1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13};
`else
    localparam int N = 15;
    localparam int EXP [N] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13};
`endif

    cordic_hyp_ctrl #(.W_Z(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .z_in(z_in),
        .stall(stall), .y_neg(y_neg), .tbl_value(tbl_value), .tbl_index(tbl_index),
        .shift(shift), .dir(dir), .step_valid(step_valid), .busy(busy), .done(done), .z_out(z_out)
    );

    always #5 clk = ~clk;

    // Stand-in table: -3 carries the real arctanh entry, others are (i+8)*2^16 for easy hand sums.
    function automatic logic signed [31:0] tbl_f(input int i);
        return (i == -3) ? 32'sh0212523D : 32'((i + 8) * 32'h10000);
    endfunction

    assign tbl_value = tbl_f(int'(tbl_index));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic check_idle_zero(input string nm);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_valid"}, step_valid, 0);
        check({nm, "_idx"}, tbl_index, 0);
        check({nm, "_shift"}, shift, 0);
        check({nm, "_dir"}, dir, 0);
        check({nm, "_zout"}, z_out, 0);
    endtask

    task automatic run_seq(input string nm, input logic m, input logic signed [31:0] zi, input logic yn,
                           input int st_lo, input int st_hi, input logic spam, output logic signed [31:0] zm);
        int k, dones, done_at, stalls, e;
        logic ed;
        logic signed [31:0] t;
        k = 0; dones = 0; done_at = -1; stalls = 0;
        @(posedge clk); #1;
        start = 1'b1; mode = m; z_in = zi; y_neg = yn; stall = 1'b0;
        zm = zi;
        for (int c = 1; c <= N + 12; c++) begin
            @(posedge clk); #1;
            start = spam && dones == 0;
            if (spam) begin
                z_in = $urandom;
                mode = ~m;
            end
            stall = c >= st_lo && c <= st_hi;
            if (stall) stalls++;
            #1;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = c;
            end
            if (stall) begin
                check({nm, "_stall_valid"}, step_valid, 0);
                check({nm, "_stall_idx"}, tbl_index, EXP[k]);
            end
            if (step_valid) begin
                if (k < N) begin
                    e = EXP[k];
                    ed = m ? yn : ~zm[31];
                    check({nm, "_idx"}, tbl_index, e);
                    check({nm, "_shift"}, shift, e <= 0 ? 2 - e : e);
                    check({nm, "_dir"}, dir, ed);
                    t = tbl_f(e);
                    zm = ed ? zm - t : zm + t;
                end
                k++;
            end
        end
        start = 1'b0;
        stall = 1'b0;
        check({nm, "_steps"}, k, N);
        check({nm, "_dones"}, dones, 1);
        check({nm, "_done_cycle"}, done_at, N + 1 + stalls);
        check({nm, "_zout"}, z_out, zm);
        check({nm, "_busy_end"}, busy, 0);
    endtask

    initial begin
        #12;
        check_idle_zero("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_idle_zero("rst_rel");

        run_seq("rot0", 1'b0, 32'sh0, 1'b0, 0, -1, 1'b0, zr);
`ifdef CORDIC_EXPANDED_RANGE_EN
        check("rot0_first_value", tbl_f(-3), 32'sh0212523D);
`endif

        run_seq("vec_neg", 1'b1, 32'sh0, 1'b1, 0, -1, 1'b0, zr);
`ifndef CORDIC_EXPANDED_RANGE_EN
        // -(sum of (i+8)) over 1..13 plus repeats 4,13 = -228 * 2^16
        check("vec_neg_hand", z_out, 32'shFF1C0000);
`endif

        run_seq("stall", 1'b0, 32'sh00800000, 1'b0, 5, 7, 1'b0, zr);
        run_seq("spam", 1'b1, 32'sh10000000, 1'b0, 0, -1, 1'b1, zr);
        mode = 1'b0;

        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0; z_in = 32'sh01000000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_mid_running", step_valid, 1);
        rst_n = 1'b0;
        #1;
        check_idle_zero("rst_mid");
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_mid_no_done", done, 0);
        end
        rst_n = 1'b1;
        #1;
        check_idle_zero("rst_mid_rel");
        run_seq("after_rst", 1'b1, 32'sh00200000, 1'b1, 0, -1, 1'b0, zr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
